rca_nibble_sequencer: RTL and testbench
=======================================

Name: rca_nibble_sequencer

Overview:
Multi-cycle WIDTH-bit adder/subtractor built around a single 4-bit ripple-carry slice. The slice is reused once per clock, least-significant nibble first, with the carry held in a register between nibbles. Start/busy/done handshake. Used wherever a wide add/subtract is needed at low area and a latency of WIDTH/4 cycles is acceptable.

Parameters:
- WIDTH, 16: operand/result width.
  - Must be a multiple of 4 and at least 4.
  - NIBBLES = WIDTH/4 is derived.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; latched when start is accepted
- b  input  WIDTH  operand B; latched when start is accepted
- cin  input  1  carry-in for add; ignored when sub=1
- sub  input  1  0: A+B+cin; 1: A-B (B inverted, initial carry 1); latched with operands
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse; sum/cout valid from this cycle on
- sum  output  WIDTH  registered result; held until the next done
- cout  output  1  carry out of the MSB; held with sum

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy=0, done=0, sum=0, cout=0; internal operand, carry and index registers cleared.
- Reset has priority over every other event, including mid-RUN. An aborted operation produces no done and leaves sum=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a, latch (sub ? ~b : b), set carry=(sub ? 1 : cin), set k=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - busy=1.
  - At each edge the slice adds a[4k+3:4k] + b'[4k+3:4k] + carry.
  - The 4-bit result is written into the internal result register at nibble k; the slice carry-out goes to the carry register; k increments.
  - On the edge that processes k=NIBBLES-1: copy the full result to sum, carry-out to cout, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge returns to IDLE.
- Latency:
  - start accepted at edge E; nibbles are processed at edges E+1..E+NIBBLES.
  - done is high in the cycle following edge E+NIBBLES.
  - With WIDTH=16, done is high 4 cycles after the accepting edge.
- Throughput: one operation per NIBBLES+2 cycles. start is ignored in RUN and DONE and is not queued; only a start seen in IDLE is accepted.
- Operand isolation: changes on a, b, cin or sub after acceptance have no effect on the running operation.
- Output stability: sum and cout change only at the edge that raises done, or on reset.
- Arithmetic: modulo 2^WIDTH.
  - Subtract with cout=1 means A>=B (no borrow).
  - cout=0 means a borrow occurred.
- WIDTH=4: a single RUN cycle.

Optional Feature:
- Macro: RCA_SEQ_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), meaning signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB, both taken from the last nibble.
  - Registered and held together with sum/cout; reset value 0.
- Not defined: port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=16):
1. Assert rst for 2 cycles with start=1 -> busy=0, done=0, sum=16'h0000, cout=0 throughout; no operation starts until rst falls.
2. Add with nibble carries: a=16'h00FF, b=16'h0001, cin=0, sub=0, start for one cycle -> busy high 4 cycles; done pulses 1 cycle; sum=16'h0100, cout=0. Then a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
3. Wrap-around: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Also a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1.
4. Subtract:
   - a=16'h0007, b=16'h0005, sub=1, cin=1 (ignored) -> sum=16'h0002, cout=1.
   - a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0.
5. Handshake and abort:
   - Pulse start again during RUN and during DONE, and change a/b mid-operation -> ignored; result matches the operands latched at acceptance.
   - Assert rst during the 2nd RUN cycle -> IDLE next cycle, no done, sum=0. A fresh start after that completes normally.
6. With RCA_SEQ_OVF_EN defined:
   - a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1.
   - a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, ovf=1.
   - a=16'h0001, b=16'h0001 -> ovf=0.
   - Without the macro, compile with no ovf port present.

Source files
------------

// File: rtl/rca_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor reusing one 4-bit ripple-carry slice, LSB nibble first.
// Optional signed-overflow output is enabled by defining RCA_SEQ_OVF_EN.
module rca_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef RCA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  // Handshake: start is sampled only in IDLE; busy is high in RUN; done pulses
  // for one cycle in DONE, and sum/cout stay valid from then until the next done.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic              carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW+1:0]     nib_lsb;
  logic [3:0]        nib_a, nib_b;
  logic [4:0]        slice;

  assign nib_lsb = {idx_q, 2'b00};
  assign nib_a   = a_q[nib_lsb +: 4];
  assign nib_b   = b_q[nib_lsb +: 4];
  assign slice   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};

`ifdef RCA_SEQ_OVF_EN
  logic       ovf_q, ovf_d;
  logic [3:0] low3;
  // Carry into the MSB of the last nibble comes from its lower three bits.
  assign low3 = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b000, carry_q};
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[nib_lsb +: 4] = slice[3:0];
        carry_d             = slice[4];
        idx_d               = idx_q + IW'(1);
        if (idx_q == LAST) begin
          sum_d   = res_d;
          cout_d  = slice[4];
`ifdef RCA_SEQ_OVF_EN
          ovf_d   = low3[3] ^ slice[4];
`endif
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;
`ifdef RCA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Bench for rca_nibble_sequencer (WIDTH=16): vector table, random ops with a reference
// model, start/operand disturbance, and reset abort. Checks ovf when RCA_SEQ_OVF_EN is set.
module tb_rca_nibble_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, cin, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic [1:0]   dbg_state;
`ifdef RCA_SEQ_OVF_EN
  logic         ovf;
`endif

  rca_nibble_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
`ifdef RCA_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset bookkeeping
  always #5 clk = ~clk;
  logic rst_edge = 1'b1;
  always @(posedge clk) rst_edge <= rst;

  int n_cmp = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];   // {ovf, cout, sum}
  logic [W+1:0] e;
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] s;
    logic         c, o;
  } vec_t;
  vec_t tv[9];

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         o;
    bb = msub ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
    o  = (ma[W-1] == bb[W-1]) && (r[W-1] != ma[W-1]);
    return {o, r};
  endfunction

  // scoreboard: pop on every done; also watch that results only move at done or reset
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("sum", {2'b00, sum}, {2'b00, e[W-1:0]});
        check("cout", {{(W+1){1'b0}}, cout}, {{(W+1){1'b0}}, e[W]});
`ifdef RCA_SEQ_OVF_EN
        check("ovf", {{(W+1){1'b0}}, ovf}, {{(W+1){1'b0}}, e[W+1]});
`endif
      end
    end else if (!rst_edge) begin
      check("hold_sum", {1'b0, cout, sum}, {1'b0, prev_cout, prev_sum});
    end
    prev_sum  = sum;
    prev_cout = cout;
  end

  // driver: one operation; optionally jiggle inputs and hold start high while it runs
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                        input logic vsub, input logic [W+1:0] exp, input bit disturb);
    int busy_cnt;
    bit got;
    busy_cnt = 0;
    got = 0;
    @(negedge clk);
    a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    #1 start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      if (disturb) begin
        a = W'($urandom); b = W'($urandom);
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        start = 1'b1;
      end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
      void'(exp_q.pop_back());
    end else begin
      check("busy_cycles", (W+2)'(busy_cnt), (W+2)'(4));
      if (disturb) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("done_pulse", {{(W+1){1'b0}}, done}, '0);
      check("idle_after", {{(W+1){1'b0}}, busy}, '0);
    end
  endtask

  initial begin
    tv[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tv[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tv[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[3] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[4] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    tv[5] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tv[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tv[8] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};

    // reset held with start asserted: nothing may start
    rst = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b1; sub = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_state", {done, busy, cout, sum}, '0);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_release_idle", {done, busy, cout, sum}, '0);

    for (int i = 0; i < 9; i++)
      run_op(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, {tv[i].o, tv[i].c, tv[i].s}, 1'b0);

    // ignored start pulses and operand changes while running
    run_op(16'h1234, 16'h0FED, 1'b1, 1'b0, {1'b0, 1'b0, 16'h2222}, 1'b1);
    run_op(16'h0100, 16'h0200, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFF00}, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), bit'(i % 2));
    end

    // abort: reset in the second RUN cycle, after a result is already held
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2345}, 1'b0);
    @(negedge clk);
    a = 16'h4000; b = 16'h4000; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", {{(W+1){1'b0}}, busy}, {{(W+1){1'b0}}, 1'b1});
    rst = 1'b1;
    @(negedge clk);
    check("abort_cleared", {done, busy, cout, sum}, '0);
    check("abort_state", {{W{1'b0}}, dbg_state}, '0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_done", {1'b0, done, sum}, '0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000}, 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
